// File: rtl/lcd_responder.sv
// Display-side model of an HD44780-style parallel LCD bus: decodes instructions,
// keeps display/entry/function state, an address counter and a small DDRAM.
module lcd_responder #(
  parameter int DEPTH        = 32,
  parameter int AW           = 5,
  parameter int EXEC_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 152
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          e,
  input  logic          rs,
  input  logic          rw,
  input  logic [7:0]    lcd_data,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy_flag,
  output logic          cmd_err,
  output logic [AW-1:0] ac,
  output logic          disp_on,
  output logic          cursor_on,
  output logic          blink_on,
  output logic          inc_dec,
  output logic          shift_en,
  output logic          lines,
  output logic          font,
  output logic          bus8,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] EXEC_N  = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] CLEAR_N = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] AC_ONE  = AW'(1);
  localparam logic [AW:0]   CLR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW:0]   clr_q;
  logic          e_q, rs_q, rw_q;
  logic [7:0]    data_q;
  logic          busy_q, cmd_err_q, rd_valid_q;
  logic [7:0]    rd_data_q, dbg_data_q;
  logic [AW-1:0] ac_q;
  logic          disp_on_q, cursor_on_q, blink_on_q;
  logic          inc_dec_q, shift_en_q;
  logic          lines_q, font_q, bus8_q;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          fall;
  logic [7:0]    status;

  assign fall   = e_q & ~e;
  assign status = {busy_q, {(7-AW){1'b0}}, ac_q};

  function automatic logic [AW-1:0] stepAc(input logic [AW-1:0] a, input logic up);
    return up ? a + AC_ONE : a - AC_ONE;
  endfunction

  // The clear sweep owns the write port; data writes can only land while idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ac_q;
    mem_wdata = data_q;
    if (state_q == CLEAR && !clr_q[AW]) begin
      mem_we    = 1'b1;
      mem_waddr = clr_q[AW-1:0];
      mem_wdata = 8'h20;
    end else if (fall && !busy_q && rs_q && !rw_q) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_data_q <= 8'h00;
    else        dbg_data_q <= mem_q[dbg_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clr_q       <= '0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      ac_q        <= '0;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      inc_dec_q   <= 1'b1;
      shift_en_q  <= 1'b0;
      lines_q     <= 1'b0;
      font_q      <= 1'b0;
      bus8_q      <= 1'b0;
    end else begin
      e_q       <= e;
      cmd_err_q <= 1'b0;
      if (e) begin
        rs_q   <= rs;
        rw_q   <= rw;
        data_q <= lcd_data;
      end

      if (e && !rs && rw) begin
        rd_data_q  <= status;
        rd_valid_q <= 1'b1;
      end else if (e && rs && rw && !busy_q) begin
        rd_data_q  <= mem_q[ac_q];
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end

      // busy_flag stays high for exactly the loaded count of cycles
      if (state_q != IDLE) begin
        if (cnt_q <= CNT_ONE) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q - CNT_ONE;
        end
        if (state_q == CLEAR && !clr_q[AW]) clr_q <= clr_q + CLR_ONE;
      end

      if (fall) begin
        if (busy_q) begin
          if (!rw_q) cmd_err_q <= 1'b1;
        end else if (rs_q) begin
          ac_q    <= stepAc(ac_q, inc_dec_q);
          state_q <= EXEC;
          cnt_q   <= EXEC_N;
          busy_q  <= 1'b1;
        end else if (!rw_q) begin
          casez (data_q)
            8'b1???????: begin
              ac_q    <= data_q[AW-1:0];
              state_q <= EXEC;
              cnt_q   <= EXEC_N;
              busy_q  <= 1'b1;
            end
            8'b01??????: begin
              state_q <= EXEC;
              cnt_q   <= EXEC_N;
              busy_q  <= 1'b1;
            end
            8'b001?????: begin
              bus8_q  <= data_q[4];
              lines_q <= data_q[3];
              font_q  <= data_q[2];
              state_q <= EXEC;
              cnt_q   <= EXEC_N;
              busy_q  <= 1'b1;
            end
            8'b0001????: begin
              if (!data_q[3]) ac_q <= stepAc(ac_q, data_q[2]);
              state_q <= EXEC;
              cnt_q   <= EXEC_N;
              busy_q  <= 1'b1;
            end
            8'b00001???: begin
              disp_on_q   <= data_q[2];
              cursor_on_q <= data_q[1];
              blink_on_q  <= data_q[0];
              state_q     <= EXEC;
              cnt_q       <= EXEC_N;
              busy_q      <= 1'b1;
            end
            8'b000001??: begin
              inc_dec_q  <= data_q[1];
              shift_en_q <= data_q[0];
              state_q    <= EXEC;
              cnt_q      <= EXEC_N;
              busy_q     <= 1'b1;
            end
            8'b0000001?: begin
              ac_q    <= '0;
              state_q <= EXEC;
              cnt_q   <= CLEAR_N;
              busy_q  <= 1'b1;
            end
            8'b00000001: begin
              ac_q      <= '0;
              inc_dec_q <= 1'b1;
              clr_q     <= '0;
              state_q   <= CLEAR;
              cnt_q     <= CLEAR_N;
              busy_q    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy_flag = busy_q;
  assign cmd_err   = cmd_err_q;
  assign ac        = ac_q;
  assign disp_on   = disp_on_q;
  assign cursor_on = cursor_on_q;
  assign blink_on  = blink_on_q;
  assign inc_dec   = inc_dec_q;
  assign shift_en  = shift_en_q;
  assign lines     = lines_q;
  assign font      = font_q;
  assign bus8      = bus8_q;
  assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: bus transactions with hand-computed expectations,
// sampled on the falling clock edge.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e, rs, rw;
  logic [7:0] lcd_data;
  logic [7:0] rd_data;
  logic       rd_valid, busy_flag, cmd_err;
  logic [4:0] ac;
  logic       disp_on, cursor_on, blink_on, inc_dec, shift_en, lines, font, bus8;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks = 0;
  int failures = 0;
  int busyLen;

  always #5 clk = ~clk;

  lcd_responder dut (
    .clk(clk), .rst_n(rst_n), .e(e), .rs(rs), .rw(rw), .lcd_data(lcd_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy_flag(busy_flag), .cmd_err(cmd_err),
    .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_dec(inc_dec), .shift_en(shift_en), .lines(lines), .font(font), .bus8(bus8),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One-cycle strobe; returns at the negedge just before the fall is executed.
  task automatic applyStimulus(input logic rsIn, input logic rwIn, input logic [7:0] dataIn);
    e = 1'b1; rs = rsIn; rw = rwIn; lcd_data = dataIn;
    @(negedge clk);
    e = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy_flag && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("idleReached", {31'd0, busy_flag}, 32'd0);
  endtask

  task automatic sendAndSettle(input logic rsIn, input logic rwIn, input logic [7:0] dataIn);
    applyStimulus(rsIn, rwIn, dataIn);
    @(negedge clk);
    waitIdle();
  endtask

  task automatic peek(input logic [4:0] addr, input logic [7:0] expected, input string tag);
    dbg_addr = addr;
    @(negedge clk);
    @(negedge clk);
    checkOutput(tag, {24'd0, dbg_data}, {24'd0, expected});
  endtask

  initial begin
    rst_n = 1'b0; e = 1'b0; rs = 1'b0; rw = 1'b0; lcd_data = 8'h00; dbg_addr = 5'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetBusy", {31'd0, busy_flag}, 32'd0);
    checkOutput("resetAc", {27'd0, ac}, 32'd0);
    checkOutput("resetIncDec", {31'd0, inc_dec}, 32'd1);
    checkOutput("resetFlags", {24'd0, disp_on, cursor_on, blink_on, shift_en, lines, font, bus8, cmd_err}, 32'd0);
    checkOutput("resetRdValid", {31'd0, rd_valid}, 32'd0);

    // Status read from reset
    e = 1'b1; rs = 1'b0; rw = 1'b1;
    @(negedge clk);
    checkOutput("statusIdleData", {24'd0, rd_data}, 32'h00);
    checkOutput("statusIdleValid", {31'd0, rd_valid}, 32'd1);
    e = 1'b0;
    @(negedge clk);
    checkOutput("statusNoSideEffect", {31'd0, busy_flag}, 32'd0);
    checkOutput("rdValidDrops", {31'd0, rd_valid}, 32'd0);

    // Function set and busy duration
    applyStimulus(1'b0, 1'b0, 8'h38);
    @(negedge clk);
    checkOutput("funcSet", {29'd0, bus8, lines, font}, 32'b110);
    busyLen = 0;
    while (busy_flag && busyLen < 1000) begin
      busyLen++;
      @(negedge clk);
    end
    checkOutput("execBusyLen", busyLen, 32'd37);

    // Entry mode, with a status read during busy
    applyStimulus(1'b0, 1'b0, 8'h06);
    @(negedge clk);
    e = 1'b1; rs = 1'b0; rw = 1'b1;
    @(negedge clk);
    checkOutput("statusBusy", {24'd0, rd_data}, 32'h80);
    e = 1'b0;
    @(negedge clk);
    checkOutput("statusNoCmdErr", {31'd0, cmd_err}, 32'd0);
    waitIdle();
    checkOutput("entryMode", {30'd0, inc_dec, shift_en}, 32'b10);

    sendAndSettle(1'b0, 1'b0, 8'h85);
    checkOutput("setDdram", {27'd0, ac}, 32'd5);
    sendAndSettle(1'b1, 1'b0, 8'h41);
    checkOutput("acAfterWrite", {27'd0, ac}, 32'd6);
    peek(5'd5, 8'h41, "ddram5");
    sendAndSettle(1'b1, 1'b0, 8'h5A);
    sendAndSettle(1'b0, 1'b0, 8'h86);
    checkOutput("acBackTo6", {27'd0, ac}, 32'd6);

    // Data write while busy is dropped
    applyStimulus(1'b0, 1'b0, 8'h0C);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h42);
    @(negedge clk);
    checkOutput("cmdErrPulse", {31'd0, cmd_err}, 32'd1);
    @(negedge clk);
    checkOutput("cmdErrSingle", {31'd0, cmd_err}, 32'd0);
    waitIdle();
    checkOutput("dispCtrl", {29'd0, disp_on, cursor_on, blink_on}, 32'b100);
    checkOutput("acUnchanged", {27'd0, ac}, 32'd6);
    peek(5'd6, 8'h5A, "ddram6Kept");

    // Full clear
    sendAndSettle(1'b0, 1'b0, 8'h04);
    applyStimulus(1'b0, 1'b0, 8'h01);
    @(negedge clk);
    busyLen = 0;
    while (busy_flag && busyLen < 1000) begin
      busyLen++;
      @(negedge clk);
    end
    checkOutput("clearBusyLen", busyLen, 32'd152);
    checkOutput("clearAc", {27'd0, ac}, 32'd0);
    checkOutput("clearIncDec", {31'd0, inc_dec}, 32'd1);
    for (int i = 0; i < 32; i++) peek(i[4:0], 8'h20, "clearEntry");

    // Reset in the middle of a clear
    sendAndSettle(1'b0, 1'b0, 8'h94);
    sendAndSettle(1'b1, 1'b0, 8'h77);
    sendAndSettle(1'b0, 1'b0, 8'h80);
    sendAndSettle(1'b1, 1'b0, 8'h33);
    applyStimulus(1'b0, 1'b0, 8'h01);
    @(negedge clk);
    repeat (11) @(negedge clk);
    checkOutput("midClearBusy", {31'd0, busy_flag}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("resetMidClear", {31'd0, busy_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) peek(i[4:0], 8'h20, "partialClear");
    peek(5'd20, 8'h77, "untouchedEntry");

    // Address wrap both ways, then data read
    sendAndSettle(1'b0, 1'b0, 8'h9F);
    sendAndSettle(1'b1, 1'b0, 8'h11);
    checkOutput("wrapUp", {27'd0, ac}, 32'd0);
    sendAndSettle(1'b0, 1'b0, 8'h04);
    sendAndSettle(1'b0, 1'b0, 8'h80);
    sendAndSettle(1'b1, 1'b0, 8'h22);
    checkOutput("wrapDown", {27'd0, ac}, 32'd31);
    e = 1'b1; rs = 1'b1; rw = 1'b1;
    @(negedge clk);
    checkOutput("dataReadValid", {31'd0, rd_valid}, 32'd1);
    checkOutput("dataReadData", {24'd0, rd_data}, 32'h11);
    e = 1'b0;
    @(negedge clk);
    checkOutput("dataReadAc", {27'd0, ac}, 32'd30);
    checkOutput("dataReadBusy", {31'd0, busy_flag}, 32'd1);
    e = 1'b1;
    @(negedge clk);
    checkOutput("busyReadInvalid", {31'd0, rd_valid}, 32'd0);
    e = 1'b0;
    @(negedge clk);
    checkOutput("busyReadNoErr", {31'd0, cmd_err}, 32'd0);
    checkOutput("busyReadAc", {27'd0, ac}, 32'd30);
    waitIdle();
    peek(5'd0, 8'h22, "ddram0Written");

    // Cursor shifts, function set, no-op
    sendAndSettle(1'b0, 1'b0, 8'h14);
    checkOutput("shiftRight", {27'd0, ac}, 32'd31);
    sendAndSettle(1'b0, 1'b0, 8'h10);
    sendAndSettle(1'b0, 1'b0, 8'h10);
    checkOutput("shiftLeft", {27'd0, ac}, 32'd29);
    sendAndSettle(1'b0, 1'b0, 8'h1C);
    checkOutput("displayShift", {27'd0, ac}, 32'd29);
    sendAndSettle(1'b0, 1'b0, 8'h24);
    checkOutput("funcSetFont", {29'd0, bus8, lines, font}, 32'b001);
    applyStimulus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("nopNotBusy", {31'd0, busy_flag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Cycle-accurate model of the display side of the HD44780-style parallel LCD bus (e, rs, rw, 8-bit data).
- Decodes the instruction set and maintains display-control state, an address counter and a small DDRAM. Reports busy status and serves status/data reads.
- Bus-facing counterpart to our LCD controller: drives rd_data back to it and exposes internal state for verification.

Parameters:
- DEPTH, 32, number of DDRAM bytes (power of 2).
- AW, 5, address counter width, log2(DEPTH).
- EXEC_CYCLES, 37, busy duration in clk cycles for ordinary instructions and data writes/reads.
- CLEAR_CYCLES, 152, busy duration for clear/return-home; must be >= DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- e  in  1  bus enable strobe, synchronous to clk.
- rs  in  1  register select: 0 instruction/status, 1 data.
- rw  in  1  0 write, 1 read.
- lcd_data  in  8  write data from controller.
- rd_data  out  8  read data returned to controller.
- rd_valid  out  1  rd_data valid.
- busy_flag  out  1  instruction in progress.
- cmd_err  out  1  one-cycle pulse: write dropped because busy.
- ac  out  AW  address counter.
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D/C/B.
- inc_dec, shift_en  out  1 each  entry-mode bits I/D and S.
- lines, font, bus8  out  1 each  function-set bits N, F, DL.
- dbg_addr  in  AW  DDRAM peek address.
- dbg_data  out  8  DDRAM[dbg_addr], registered, 1-cycle latency.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, except inc_dec=1.
  - State=IDLE, busy counter=0.
  - DDRAM contents not reset.
- Strobe:
  - e_q is e registered.
  - While e=1, rs/rw/lcd_data are latched every cycle.
  - Fall = e_q & ~e; the instruction executes on the edge where Fall is first seen.
  - All state updates and busy_flag assertion occur at that edge.
- Status read (rs=0, rw=1):
  - While e=1, rd_data <= {busy_flag, {(7-AW){0}}, ac} and rd_valid=1, each cycle.
  - Served even when busy. No side effect on fall.
- Data read (rs=1, rw=1):
  - While e=1 and not busy, rd_data <= DDRAM[ac] and rd_valid=1.
  - On fall: ac steps per I/D and busy starts for EXEC_CYCLES.
  - If busy: rd_valid=0 and nothing happens on fall.
- rd_valid=0 whenever e=0.
- Writes (rw=0) on fall when busy_flag=1: ignored; cmd_err pulses one cycle.
- Instruction decode (rs=0, rw=0), highest set bit wins:
  - 0x01 clear: go to CLEAR. Write 0x20 to DDRAM[0..DEPTH-1], one entry per cycle ascending. ac=0, inc_dec=1. Busy for CLEAR_CYCLES.
  - 0x02-0x03 return home: ac=0, busy CLEAR_CYCLES.
  - 0x04-0x07 entry mode: inc_dec=bit1, shift_en=bit0.
  - 0x08-0x0F display control: disp_on=bit2, cursor_on=bit1, blink_on=bit0.
  - 0x10-0x1F cursor/display shift:
    - bit3=0: ac steps +1 if bit2=1, else -1.
    - bit3=1: no ac change.
  - 0x20-0x3F function set: bus8=bit4, lines=bit3, font=bit2.
  - 0x40-0x7F set CGRAM address: accepted, no state change.
  - 0x80-0xFF set DDRAM address: ac=lcd_data[AW-1:0].
  - 0x00: no-op, no busy.
  - All other decoded instructions: busy EXEC_CYCLES unless stated otherwise.
- Data write (rs=1, rw=0): DDRAM[ac]=lcd_data; ac steps +1 (inc_dec=1) or -1; busy EXEC_CYCLES.
- ac arithmetic is modulo DEPTH: 31+1 -> 0, 0-1 -> 31.
- State machine:
  - IDLE -> EXEC on any timed instruction; busy counter loaded with N.
  - IDLE -> CLEAR on 0x01.
  - EXEC/CLEAR: count down; return to IDLE when the counter reaches 0.
  - busy_flag=1 for exactly N cycles.
  - A new fall in the cycle after busy_flag drops is accepted.
- Reset mid-CLEAR: immediate IDLE; partially cleared DDRAM kept as is.

Test Plan:
- Reset, then status read (e=1, rs=0, rw=1) -> rd_data=0x00, rd_valid=1, busy_flag=0.
- Write 0x38 -> bus8=1, lines=1, font=0; busy_flag high exactly 37 cycles; status read during busy -> rd_data[7]=1.
- Write 0x06, 0x85, then data 0x41 -> dbg_addr=5 gives dbg_data=0x41; ac=6; inc_dec=1.
- Data write 0x42 while busy -> cmd_err single-cycle pulse; DDRAM[6] unchanged; ac stays 6.
- Write 0x01 -> all 32 DDRAM entries 0x20, ac=0, busy 152 cycles. Assert rst_n=0 at cycle 10 of the clear -> IDLE, busy_flag=0, entries 0..9 already 0x20.
- Wrap: 0x9F then data write with I/D=1 -> ac=0. Then 0x04, 0x80, data write -> ac=31. Data read at ac=31 -> rd_data=DDRAM[31], ac=30 after fall.
